// File: rtl/hc_pkg.sv
// Shared types and line geometry for the hc_core_dispatch slice.
package hc_pkg;

  localparam int HC_LINE_ADDR_W = 42;
  localparam int HC_LINE_DATA_W = 512;

  typedef enum logic [1:0] {
    HC_IDLE  = 2'd0,
    HC_RUN   = 2'd1,
    HC_DRAIN = 2'd2,
    HC_DONE  = 2'd3
  } t_hc_dispatch_state;

endpackage

// File: rtl/hc_rr_arbiter.sv
// Round-robin arbiter: the lowest requesting index at or after the pointer wins,
// and the pointer moves to one past the winner.
module hc_rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CORES-1:0] request,
  output logic [NUM_CORES-1:0] grant,
  output logic [ID_W-1:0]      grantId,
  output logic                 grantValid
);

  logic [ID_W-1:0] pointer;

  always_comb begin
    logic [ID_W:0] slot;
    slot       = '0;
    grant      = '0;
    grantId    = '0;
    grantValid = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      slot = {1'b0, pointer} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(NUM_CORES)) slot = slot - (ID_W+1)'(NUM_CORES);
      if (!grantValid && request[slot[ID_W-1:0]]) begin
        grantValid                = 1'b1;
        grant[slot[ID_W-1:0]]     = 1'b1;
        grantId                   = slot[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pointer <= '0;
    end else if (grantValid) begin
      pointer <= (grantId == ID_W'(NUM_CORES - 1)) ? '0 : grantId + ID_W'(1);
    end
  end

endmodule

// File: rtl/hc_core_dispatch.sv
// Multiplexes per-core read/write requests onto CCI-P c0/c1 with per-core credit limits.
// Optional perf counters are built when HC_CORE_DISPATCH_PERF_EN is defined.
module hc_core_dispatch
  import hc_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int MDATA_W         = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  output logic                                     finish,
  output logic                                     err_bad_id,
`ifdef HC_CORE_DISPATCH_PERF_EN
  output logic [NUM_CORES-1:0][31:0]               perf_rd_cnt,
  output logic [NUM_CORES-1:0][31:0]               perf_wr_cnt,
  output logic [31:0]                              perf_cycles,
`endif
  output logic [NUM_CORES-1:0]                     core_start,
  input  logic [NUM_CORES-1:0]                     core_finish,
  input  logic [NUM_CORES-1:0]                     core_rd_valid,
  output logic [NUM_CORES-1:0]                     core_rd_ready,
  input  logic [NUM_CORES-1:0][HC_LINE_ADDR_W-1:0] core_rd_addr,
  output logic [NUM_CORES-1:0]                     core_rd_rsp_valid,
  output logic [HC_LINE_DATA_W-1:0]                core_rd_rsp_data,
  input  logic [NUM_CORES-1:0]                     core_wr_valid,
  output logic [NUM_CORES-1:0]                     core_wr_ready,
  input  logic [NUM_CORES-1:0][HC_LINE_ADDR_W-1:0] core_wr_addr,
  input  logic [NUM_CORES-1:0][HC_LINE_DATA_W-1:0] core_wr_data,
  output logic [NUM_CORES-1:0]                     core_wr_rsp_valid,
  output logic                                     c0_tx_valid,
  output logic [HC_LINE_ADDR_W-1:0]                c0_tx_addr,
  output logic [MDATA_W-1:0]                       c0_tx_mdata,
  input  logic                                     c0_tx_almfull,
  input  logic                                     c0_rx_valid,
  input  logic [MDATA_W-1:0]                       c0_rx_mdata,
  input  logic [HC_LINE_DATA_W-1:0]                c0_rx_data,
  output logic                                     c1_tx_valid,
  output logic [HC_LINE_ADDR_W-1:0]                c1_tx_addr,
  output logic [HC_LINE_DATA_W-1:0]                c1_tx_data,
  output logic [MDATA_W-1:0]                       c1_tx_mdata,
  input  logic                                     c1_tx_almfull,
  input  logic                                     c1_rx_valid,
  input  logic [MDATA_W-1:0]                       c1_rx_mdata
);

  localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  t_hc_dispatch_state   state;
  logic [NUM_CORES-1:0] doneMask;
  logic [CNT_W-1:0]     rdCnt [NUM_CORES];
  logic [CNT_W-1:0]     wrCnt [NUM_CORES];
  logic [NUM_CORES-1:0] rdElig, wrElig, rdGrant, wrGrant, rdRspHit, wrRspHit;
  logic [ID_W-1:0]      rdGrantId, wrGrantId;
  logic                 rdGrantValid, wrGrantValid, rdRspOk, wrRspOk, allIdle;

  // Response decrements never take a counter below zero, so stale responses after a reset are harmless.
  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0) res = cnt - CNT_W'(1);
    return res;
  endfunction

  always_comb begin
    rdElig   = '0;
    wrElig   = '0;
    rdRspHit = '0;
    wrRspHit = '0;
    allIdle  = 1'b1;
    rdRspOk  = c0_rx_valid && (c0_rx_mdata < MDATA_W'(NUM_CORES));
    wrRspOk  = c1_rx_valid && (c1_rx_mdata < MDATA_W'(NUM_CORES));
    for (int i = 0; i < NUM_CORES; i++) begin
      rdElig[i]   = reset_n && core_rd_valid[i] && !c0_tx_almfull
                    && (rdCnt[i] < CNT_W'(MAX_OUTSTANDING));
      wrElig[i]   = reset_n && core_wr_valid[i] && !c1_tx_almfull
                    && (wrCnt[i] < CNT_W'(MAX_OUTSTANDING));
      rdRspHit[i] = rdRspOk && (c0_rx_mdata[ID_W-1:0] == ID_W'(i));
      wrRspHit[i] = wrRspOk && (c1_rx_mdata[ID_W-1:0] == ID_W'(i));
      if (rdCnt[i] != '0 || wrCnt[i] != '0) allIdle = 1'b0;
    end
  end

  hc_rr_arbiter #(.NUM_CORES(NUM_CORES), .ID_W(ID_W)) rdArb (
    .clk(clk), .reset_n(reset_n), .request(rdElig),
    .grant(rdGrant), .grantId(rdGrantId), .grantValid(rdGrantValid)
  );

  hc_rr_arbiter #(.NUM_CORES(NUM_CORES), .ID_W(ID_W)) wrArb (
    .clk(clk), .reset_n(reset_n), .request(wrElig),
    .grant(wrGrant), .grantId(wrGrantId), .grantValid(wrGrantValid)
  );

  assign core_rd_ready = rdGrant;
  assign core_wr_ready = wrGrant;

  // Stage p1: accepted requests and routed responses, one cycle after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_tx_valid       <= 1'b0;
      c0_tx_addr        <= '0;
      c0_tx_mdata       <= '0;
      c1_tx_valid       <= 1'b0;
      c1_tx_addr        <= '0;
      c1_tx_data        <= '0;
      c1_tx_mdata       <= '0;
      core_rd_rsp_valid <= '0;
      core_rd_rsp_data  <= '0;
      core_wr_rsp_valid <= '0;
      err_bad_id        <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        rdCnt[i] <= '0;
        wrCnt[i] <= '0;
      end
    end else begin
      c0_tx_valid <= rdGrantValid;
      if (rdGrantValid) begin
        c0_tx_addr  <= core_rd_addr[rdGrantId];
        c0_tx_mdata <= MDATA_W'(rdGrantId);
      end
      c1_tx_valid <= wrGrantValid;
      if (wrGrantValid) begin
        c1_tx_addr  <= core_wr_addr[wrGrantId];
        c1_tx_data  <= core_wr_data[wrGrantId];
        c1_tx_mdata <= MDATA_W'(wrGrantId);
      end
      core_rd_rsp_valid <= rdRspHit;
      core_wr_rsp_valid <= wrRspHit;
      if (rdRspOk) core_rd_rsp_data <= c0_rx_data;
      if ((c0_rx_valid && !rdRspOk) || (c1_rx_valid && !wrRspOk)) err_bad_id <= 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        rdCnt[i] <= nextCount(rdCnt[i], rdGrant[i], rdRspHit[i]);
        wrCnt[i] <= nextCount(wrCnt[i], wrGrant[i], wrRspHit[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HC_IDLE;
      core_start <= '0;
      doneMask   <= '0;
      finish     <= 1'b0;
    end else begin
      core_start <= '0;
      case (state)
        HC_IDLE, HC_DONE: begin
          if (start) begin
            state      <= HC_RUN;
            core_start <= '1;
            doneMask   <= '0;
            finish     <= 1'b0;
          end
        end
        HC_RUN: begin
          doneMask <= doneMask | core_finish;
          if (&doneMask) state <= HC_DRAIN;
        end
        HC_DRAIN: begin
          if (allIdle) begin
            state  <= HC_DONE;
            finish <= 1'b1;
          end
        end
        default: state <= HC_IDLE;
      endcase
    end
  end

`ifdef HC_CORE_DISPATCH_PERF_EN
  logic enterRun;
  assign enterRun = start && (state == HC_IDLE || state == HC_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
      perf_cycles <= '0;
    end else if (enterRun) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == HC_RUN) perf_cycles <= perf_cycles + 32'd1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (rdGrant[i]) perf_rd_cnt[i] <= perf_rd_cnt[i] + 32'd1;
        if (wrGrant[i]) perf_wr_cnt[i] <= perf_wr_cnt[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hc_core_dispatch.md
HC_CORE_DISPATCH -- requirements
Module: hc_core_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 4, meaning number of attached cores (1..16); ID_W = max(1, clog2(NUM_CORES)).
REQ-002 Parameter MAX_OUTSTANDING, default 32, meaning per-core, per-channel limit on in-flight requests (2..256).
REQ-003 Parameter MDATA_W, default 16, meaning CCI-P mdata width; ID_W <= MDATA_W.
REQ-004 clk  in  1  sole clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  job-start pulse from the requestor.
REQ-007 finish  out  1  all cores done and drained.
REQ-008 err_bad_id  out  1  sticky; a response carried an ID >= NUM_CORES.
REQ-009 core_start  out  NUM_CORES  per-core start pulse.
REQ-010 core_finish  in  NUM_CORES  per-core done level.
REQ-011 core_rd_valid, core_rd_ready  in/out  NUM_CORES  read request handshake; core_rd_addr  in  NUM_CORES x 42  line address.
REQ-012 core_rd_rsp_valid  out  NUM_CORES; core_rd_rsp_data  out  512  shared read data bus.
REQ-013 core_wr_valid, core_wr_ready  in/out  NUM_CORES; core_wr_addr  in  NUM_CORES x 42; core_wr_data  in  NUM_CORES x 512; core_wr_rsp_valid  out  NUM_CORES.
REQ-014 c0_tx_valid  out  1, c0_tx_addr  out  42, c0_tx_mdata  out  MDATA_W, c0_tx_almfull  in  1; c0_rx_valid  in  1, c0_rx_mdata  in  MDATA_W, c0_rx_data  in  512.
REQ-015 c1_tx_valid  out  1, c1_tx_addr  out  42, c1_tx_data  out  512, c1_tx_mdata  out  MDATA_W, c1_tx_almfull  in  1; c1_rx_valid  in  1, c1_rx_mdata  in  MDATA_W.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN when done_mask is all ones; DRAIN->DONE when every outstanding counter is 0; DONE->RUN on start.
REQ-017 On entering RUN, core_start shall be all ones for exactly one cycle and done_mask shall be cleared; start in RUN or DRAIN shall be ignored.
REQ-018 done_mask[i] sets when core_finish[i]=1 in RUN; finish=1 only in DONE.
REQ-019 Each channel: round-robin arbiter; eligible core = valid AND counter < MAX_OUTSTANDING AND almfull=0; the lowest eligible index >= pointer (wrapping) wins; pointer = winner+1 mod NUM_CORES.
REQ-020 The core_*_ready is combinational and asserted to the winner only; a transfer occurs on valid&ready.
REQ-021 The request shall appear on c*_tx_* the cycle after transfer (1-cycle latency); c*_tx_mdata[ID_W-1:0]=core ID, upper bits 0; c*_tx_valid otherwise 0.
REQ-022 A response shall be registered and routed: core_*_rsp_valid[id] high one cycle after c*_rx_valid, with rd data on core_rd_rsp_data.
REQ-023 Counter +1 on issue, -1 on response; simultaneous issue and response on the same core leaves it unchanged; decrement saturates at 0.
REQ-024 A response with ID >= NUM_CORES is dropped, sets err_bad_id, and changes no counter.
REQ-025 Arbitration remains active in DRAIN and DONE; only start/finish sequencing is state-gated.

Reset
REQ-026 While reset_n=0: state IDLE, pointers 0, counters 0, done_mask 0, err_bad_id 0, and every output 0 (core_rd_rsp_data 0).
REQ-027 Reset mid-operation abandons in-flight requests; later responses follow REQ-023 saturation.

Configuration
REQ-028 With HC_CORE_DISPATCH_PERF_EN defined: per-core 32-bit rd/wr issue counters and a 32-bit RUN-cycle counter, cleared on entering RUN, wrapping at 2^32, exposed as perf_rd_cnt, perf_wr_cnt (NUM_CORES x 32) and perf_cycles (32).
REQ-029 Without the macro these ports and registers are absent and behaviour is otherwise identical.

Structure
REQ-030 The hc_pkg package holds the FSM enum t_hc_dispatch_state, HC_LINE_ADDR_W=42 and HC_LINE_DATA_W=512.
REQ-031 One sub-module, hc_rr_arbiter (NUM_CORES parameter, request/grant vector, pointer), instantiated once per channel.

Verification
REQ-032 NUM_CORES=4, all cores rd_valid continuously: grants shall follow the order 0,1,2,3,0 with c0_tx_mdata 0,1,2,3,0 on consecutive cycles.
REQ-033 c0_tx_almfull=1 for 5 cycles: there shall be no ready and no c0_tx_valid; issue resumes with the pointer unchanged.
REQ-034 MAX_OUTSTANDING=2, core 1 issues 2 reads with no responses: core_rd_ready[1] stays 0; one response with mdata=1 re-enables it the next cycle.
REQ-035 core_finish=4'b1111 with 3 reads outstanding: state DRAIN and finish=0; after 3 responses, finish=1 one cycle later.
REQ-036 c1_rx_mdata=7 with NUM_CORES=4: err_bad_id=1 and no wr_rsp_valid; reset_n pulsed low mid-RUN clears all outputs asynchronously.
